// File: rtl/mem_wb_stage.sv
// mem_wb_stage
//   MEM/WB pipeline stage between data-memory / ALU result and register-file
//   write-back. A head register drives the Out* fields and a single skid
//   register absorbs one extra entry, so downstream back-pressure never drops
//   a transfer. InReady is registered (no combinational OutReady->InReady
//   path). The write-back data select is made at capture and stored.
//
// Parameters
//   DATA_W    width of ReadData / AluResult / write-back data
//   REG_AW    register-file address width
//   ZERO_REG  when nonzero, a captured entry with destination 0 stores RegWrite=0
//
// Ports
//   Clk, Rst (sync, active-high), Flush (sync, active-high)
//   InValid/InReady                         upstream handshake
//   InRegWrite, InMemtoReg, InReadData, InAluResult, InMux   incoming entry
//   OutValid/OutReady                       downstream handshake
//   OutRegWrite (gated by OutValid), OutMemtoReg, OutReadData,
//   OutAluResult, OutMux, OutWriteData      head entry
//   Occupancy                               entries held (0..2)
//
// Optional feature (macro MEMWB_FWD_EN)
//   Adds SrcA/SrcB inputs and FwdA/FwdB/FwdData forwarding outputs,
//   combinational from the head entry and the Src inputs.
module mem_wb_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic              InRegWrite,
  input  logic              InMemtoReg,
  input  logic [DATA_W-1:0] InReadData,
  input  logic [DATA_W-1:0] InAluResult,
  input  logic [REG_AW-1:0] InMux,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              OutRegWrite,
  output logic              OutMemtoReg,
  output logic [DATA_W-1:0] OutReadData,
  output logic [DATA_W-1:0] OutAluResult,
  output logic [REG_AW-1:0] OutMux,
  output logic [DATA_W-1:0] OutWriteData,
  output logic [1:0]        Occupancy
`ifdef MEMWB_FWD_EN
  ,
  input  logic [REG_AW-1:0] SrcA,
  input  logic [REG_AW-1:0] SrcB,
  output logic              FwdA,
  output logic              FwdB,
  output logic [DATA_W-1:0] FwdData
`endif
);

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] mux;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  // Encoding equals the number of held entries so Occupancy is the state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  entry_t cap;
  logic   in_xfer;
  logic   out_xfer;

  always_comb begin
    cap          = '0;
    cap.regwrite = InRegWrite & ~((ZERO_REG != 0) && (InMux == '0));
    cap.memtoreg = InMemtoReg;
    cap.rdata    = InReadData;
    cap.alu      = InAluResult;
    cap.mux      = InMux;
    cap.wdata    = InMemtoReg ? InReadData : InAluResult;
  end

  assign in_xfer  = InValid & in_ready_q;
  assign out_xfer = (state_q != EMPTY) & OutReady;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          head_d  = cap;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = cap;
        end else if (in_xfer) begin
          state_d = TWO;
          skid_d  = cap;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush discards everything including a same-cycle capture; data fields
    // may go stale but control must read 0 afterwards.
    if (Flush) begin
      state_d         = EMPTY;
      head_d          = head_q;
      skid_d          = skid_q;
      head_d.regwrite = 1'b0;
      head_d.memtoreg = 1'b0;
    end

    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign InReady      = in_ready_q;
  assign OutValid     = (state_q != EMPTY);
  assign OutRegWrite  = head_q.regwrite & OutValid;
  assign OutMemtoReg  = head_q.memtoreg;
  assign OutReadData  = head_q.rdata;
  assign OutAluResult = head_q.alu;
  assign OutMux       = head_q.mux;
  assign OutWriteData = head_q.wdata;
  assign Occupancy    = state_q;

`ifdef MEMWB_FWD_EN
  assign FwdA    = OutValid & OutRegWrite & (OutMux == SrcA) & (SrcA != '0);
  assign FwdB    = OutValid & OutRegWrite & (OutMux == SrcB) & (SrcB != '0);
  assign FwdData = OutWriteData;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage
//   Scoreboard bench for mem_wb_stage. The driver issues entries and pushes
//   each accepted one (as a FIFO of at most two entries) into a queue; the
//   monitor compares the DUT head against the queue front every cycle and
//   pops on downstream transfers. A second instance with ZERO_REG=0 shares
//   the stimulus to cover the non-squashing write-back enable.
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              Clk;
  logic              Rst;
  logic              Flush;
  logic              InValid;
  logic              InReady;
  logic              InRegWrite;
  logic              InMemtoReg;
  logic [DATA_W-1:0] InReadData;
  logic [DATA_W-1:0] InAluResult;
  logic [REG_AW-1:0] InMux;
  logic              OutValid;
  logic              OutReady;
  logic              OutRegWrite;
  logic              OutMemtoReg;
  logic [DATA_W-1:0] OutReadData;
  logic [DATA_W-1:0] OutAluResult;
  logic [REG_AW-1:0] OutMux;
  logic [DATA_W-1:0] OutWriteData;
  logic [1:0]        Occupancy;

  logic              InReady0;
  logic              OutValid0;
  logic              OutRegWrite0;
  logic              OutMemtoReg0;
  logic [DATA_W-1:0] OutReadData0;
  logic [DATA_W-1:0] OutAluResult0;
  logic [REG_AW-1:0] OutMux0;
  logic [DATA_W-1:0] OutWriteData0;
  logic [1:0]        Occupancy0;

  logic [REG_AW-1:0] SrcA;
  logic [REG_AW-1:0] SrcB;
`ifdef MEMWB_FWD_EN
  logic              FwdA;
  logic              FwdB;
  logic [DATA_W-1:0] FwdData;
  logic              FwdA0;
  logic              FwdB0;
  logic [DATA_W-1:0] FwdData0;
`endif

  mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(1)) u_dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .InRegWrite(InRegWrite), .InMemtoReg(InMemtoReg),
    .InReadData(InReadData), .InAluResult(InAluResult), .InMux(InMux),
    .OutValid(OutValid), .OutReady(OutReady),
    .OutRegWrite(OutRegWrite), .OutMemtoReg(OutMemtoReg),
    .OutReadData(OutReadData), .OutAluResult(OutAluResult), .OutMux(OutMux),
    .OutWriteData(OutWriteData), .Occupancy(Occupancy)
`ifdef MEMWB_FWD_EN
    , .SrcA(SrcA), .SrcB(SrcB), .FwdA(FwdA), .FwdB(FwdB), .FwdData(FwdData)
`endif
  );

  mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(0)) u_dut0 (
    .Clk(Clk), .Rst(Rst), .Flush(Flush),
    .InValid(InValid), .InReady(InReady0),
    .InRegWrite(InRegWrite), .InMemtoReg(InMemtoReg),
    .InReadData(InReadData), .InAluResult(InAluResult), .InMux(InMux),
    .OutValid(OutValid0), .OutReady(OutReady),
    .OutRegWrite(OutRegWrite0), .OutMemtoReg(OutMemtoReg0),
    .OutReadData(OutReadData0), .OutAluResult(OutAluResult0), .OutMux(OutMux0),
    .OutWriteData(OutWriteData0), .Occupancy(Occupancy0)
`ifdef MEMWB_FWD_EN
    , .SrcA(SrcA), .SrcB(SrcB), .FwdA(FwdA0), .FwdB(FwdB0), .FwdData(FwdData0)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic              rw1;
    logic              rw0;
    logic              m2r;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [REG_AW-1:0] mux;
    logic [DATA_W-1:0] wd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  bit   have_head = 1'b0;
  bit   ctl_clr = 1'b0;
  bit   rst_clr = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare state after each edge, pop on downstream transfers.
  initial begin
    forever begin
      @(posedge Clk);
      #3;
      if (armed) begin
        int n;
        n = q.size();
        chk("occupancy", 64'(Occupancy), 64'(n));
        chk("in_ready", 64'(InReady), 64'(n < 2));
        chk("out_valid", 64'(OutValid), 64'(n != 0));
        chk("out_valid_z0", 64'(OutValid0), 64'(n != 0));
        if (n != 0) begin
          chk("out_regwrite", 64'(OutRegWrite), 64'(q[0].rw1));
          chk("out_regwrite_z0", 64'(OutRegWrite0), 64'(q[0].rw0));
          chk("out_memtoreg", 64'(OutMemtoReg), 64'(q[0].m2r));
          chk("out_readdata", 64'(OutReadData), 64'(q[0].rd));
          chk("out_aluresult", 64'(OutAluResult), 64'(q[0].alu));
          chk("out_mux", 64'(OutMux), 64'(q[0].mux));
          chk("out_writedata", 64'(OutWriteData), 64'(q[0].wd));
        end else begin
          chk("idle_regwrite", 64'(OutRegWrite), 64'(0));
          chk("idle_regwrite_z0", 64'(OutRegWrite0), 64'(0));
          if (ctl_clr) chk("cleared_memtoreg", 64'(OutMemtoReg), 64'(0));
          if (rst_clr) begin
            chk("reset_readdata", 64'(OutReadData), 64'(0));
            chk("reset_aluresult", 64'(OutAluResult), 64'(0));
            chk("reset_mux", 64'(OutMux), 64'(0));
            chk("reset_writedata", 64'(OutWriteData), 64'(0));
          end
        end
`ifdef MEMWB_FWD_EN
        chk("fwd_a", 64'(FwdA),
            64'((n != 0) && q[0].rw1 && (q[0].mux == SrcA) && (SrcA != 0)));
        chk("fwd_b", 64'(FwdB),
            64'((n != 0) && q[0].rw1 && (q[0].mux == SrcB) && (SrcB != 0)));
        if (n != 0) chk("fwd_data", 64'(FwdData), 64'(q[0].wd));
`endif
        have_head = (n != 0);
      end else begin
        have_head = 1'b0;
      end
      @(negedge Clk);
      #2;
      if (armed && have_head && OutReady && !Rst && !Flush) void'(q.pop_front());
    end
  end

  // One cycle of stimulus; acc reports whether the model accepts the entry.
  task automatic tick(input logic v, input logic rw, input logic m2r,
                      input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] alu,
                      input logic [REG_AW-1:0] mux, input logic ordy,
                      input logic fl, input logic rs, output bit acc);
    exp_t e;
    @(negedge Clk);
    InValid     = v;
    InRegWrite  = rw;
    InMemtoReg  = m2r;
    InReadData  = rd;
    InAluResult = alu;
    InMux       = mux;
    OutReady    = ordy;
    Flush       = fl;
    Rst         = rs;
    #1;
    acc = 1'b0;
    if (rs || fl) begin
      q.delete();
      ctl_clr = 1'b1;
      if (rs) rst_clr = 1'b1;
    end else if (v && q.size() < 2) begin
      e.rw1 = rw && (mux != 0);
      e.rw0 = rw;
      e.m2r = m2r;
      e.rd  = rd;
      e.alu = alu;
      e.mux = mux;
      e.wd  = m2r ? rd : alu;
      q.push_back(e);
      ctl_clr = 1'b0;
      rst_clr = 1'b0;
      acc = 1'b1;
    end
  endtask

  task automatic send(input logic rw, input logic m2r, input logic [DATA_W-1:0] rd,
                      input logic [DATA_W-1:0] alu, input logic [REG_AW-1:0] mux,
                      input logic ordy);
    bit acc;
    int unsigned tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 40) begin
      tick(1'b1, rw, m2r, rd, alu, mux, ordy, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: entry mux=%0d not accepted within 40 cycles", mux);
    end
  endtask

  task automatic idle(input logic ordy, input int unsigned cycles);
    bit acc;
    for (int unsigned i = 0; i < cycles; i++)
      tick(1'b0, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    Rst = 1'b1; Flush = 1'b0; InValid = 1'b0; InRegWrite = 1'b0; InMemtoReg = 1'b0;
    InReadData = '0; InAluResult = '0; InMux = '0; OutReady = 1'b0;
    SrcA = '0; SrcB = '0;

    // Reset for two cycles, then check reset state.
    tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    tick(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    armed = 1'b1;
    idle(1'b0, 1);

    // Single transfer, memory-read select.
    send(1'b1, 1'b1, 32'hDEADBEEF, 32'h10, 5'd7, 1'b1);
    idle(1'b1, 2);

    // Back-pressure: A, B fill the stage, C is held upstream.
    send(1'b1, 1'b0, 32'h0, 32'd1, 5'd1, 1'b0);
    send(1'b1, 1'b0, 32'h0, 32'd2, 5'd2, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 32'd3, 5'd3, 1'b0, 1'b0, 1'b0, acc);
    tick(1'b1, 1'b1, 1'b0, 32'h0, 32'd3, 5'd3, 1'b0, 1'b0, 1'b0, acc);
    send(1'b1, 1'b0, 32'h0, 32'd3, 5'd3, 1'b1);
    idle(1'b1, 4);

    // Streaming: 8 back-to-back entries.
    for (int unsigned i = 0; i < 8; i++)
      send(1'b1, i[0], $urandom, $urandom, REG_AW'(i + 8), 1'b1);
    idle(1'b1, 3);

    // Flush with a full buffer and a valid input in the flush cycle.
    send(1'b1, 1'b1, 32'hAAAA0001, 32'h1, 5'd9, 1'b0);
    send(1'b1, 1'b1, 32'hAAAA0002, 32'h2, 5'd10, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 32'hBAD, 32'hBAD, 5'd11, 1'b0, 1'b1, 1'b0, acc);
    idle(1'b1, 2);

    // Zero-register squash (ZERO_REG=1) versus pass-through (ZERO_REG=0).
    send(1'b1, 1'b0, 32'h0, 32'h1234, 5'd0, 1'b0);
    idle(1'b0, 1);
    idle(1'b1, 2);

    // Forwarding from the head entry.
    send(1'b1, 1'b0, 32'h0, 32'h55, 5'd5, 1'b0);
    SrcA = 5'd5; SrcB = 5'd6;
    idle(1'b0, 2);
    SrcA = 5'd0;
    idle(1'b0, 1);
    SrcB = 5'd5;
    idle(1'b1, 2);

    // Randomised traffic with occasional flush and reset.
    for (int unsigned i = 0; i < 500; i++) begin
      logic fl, rs;
      SrcA = REG_AW'($urandom_range(0, 7));
      SrcB = REG_AW'($urandom_range(0, 7));
      rs = ($urandom_range(0, 79) == 0);
      fl = ($urandom_range(0, 29) == 0);
      tick(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), $urandom, $urandom,
           REG_AW'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0), fl, rs, acc);
    end
    idle(1'b1, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
